// File: rtl/alu_operand_stage.sv
// Decode/operand stage: 32-entry register file, ALU operand formation and a
// single-entry valid/ready pipeline register. Optional macro ALU_OPERAND_WB_BYPASS_EN.
module alu_operand_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CTRL_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [15:0]           imm,
  input  logic                  use_imm,
  input  logic                  imm_sext,
  input  logic [CTRL_W-1:0]     alu_control_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic                  reg_write_in,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     a,
  output logic [DATA_W-1:0]     b,
  output logic [CTRL_W-1:0]     alu_control,
  output logic [DATA_W-1:0]     rt_data,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic                  reg_write_out
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
  localparam int unsigned IMM_W    = 16;

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] imm_ext;
  logic              wb_wr;
  logic              capture;

  logic                  valid_q,  valid_d;
  logic [DATA_W-1:0]     a_q,      a_d;
  logic [DATA_W-1:0]     b_q,      b_d;
  logic [CTRL_W-1:0]     ctrl_q,   ctrl_d;
  logic [DATA_W-1:0]     rt_q,     rt_d;
  logic [REG_ADDR_W-1:0] rd_q,     rd_d;
  logic                  rw_q,     rw_d;

  assign wb_wr    = wb_en & (wb_addr != '0);
  assign in_ready = rst_n & (~valid_q | out_ready);
  assign capture  = in_valid & in_ready;

  // Register file: reg[0] is never written, so it always reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_wr) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Read ports and operand formation.
  always_comb begin
    rs_val = (rs_addr == '0) ? '0 : regs_q[rs_addr];
    rt_val = (rt_addr == '0) ? '0 : regs_q[rt_addr];
`ifdef ALU_OPERAND_WB_BYPASS_EN
    if (wb_wr && (wb_addr == rs_addr)) rs_val = wb_data;
    if (wb_wr && (wb_addr == rt_addr)) rt_val = wb_data;
`endif
    imm_ext = imm_sext ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                       : {{(DATA_W-IMM_W){1'b0}}, imm};
  end

  // Pipeline register next state: flush beats capture beats drain.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    if (flush) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      a_d     = rs_val;
      b_d     = use_imm ? imm_ext : rt_val;
      ctrl_d  = alu_control_in;
      rt_d    = rt_val;
      rd_d    = rd_addr_in;
      rw_d    = reg_write_in;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
    end
  end

  assign out_valid     = valid_q;
  assign a             = a_q;
  assign b             = b_q;
  assign alu_control   = ctrl_q;
  assign rt_data       = rt_q;
  assign rd_addr_out   = rd_q;
  assign reg_write_out = rw_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus a random
// run against a behavioural model of the register file and pipeline entry.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, use_imm, imm_sext, reg_write_in;
  logic        wb_en, flush, out_valid, out_ready, reg_write_out;
  logic [4:0]  rs_addr, rt_addr, rd_addr_in, wb_addr, rd_addr_out;
  logic [15:0] imm;
  logic [3:0]  alu_control_in, alu_control;
  logic [31:0] wb_data, a, b, rt_data;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic        m_valid, m_rw;
  logic [31:0] m_a, m_b, m_rt;
  logic [3:0]  m_ctrl;
  logic [4:0]  m_rd;

`ifdef ALU_OPERAND_WB_BYPASS_EN
  localparam logic [31:0] SAME_EDGE_EXP = 32'h20;
`else
  localparam logic [31:0] SAME_EDGE_EXP = 32'h10;
`endif

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm), .use_imm(use_imm),
    .imm_sext(imm_sext), .alu_control_in(alu_control_in), .rd_addr_in(rd_addr_in),
    .reg_write_in(reg_write_in), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b),
    .alu_control(alu_control), .rt_data(rt_data), .rd_addr_out(rd_addr_out),
    .reg_write_out(reg_write_out)
  );

  function automatic logic model_ready();
    return rst_n && (!m_valid || out_ready);
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [31:0] ra, rtv, immv;
    bit          writes;
    writes = wb_en && (wb_addr != 5'd0);
    ra  = (rs_addr == 5'd0) ? 32'd0 : m_regs[rs_addr];
    rtv = (rt_addr == 5'd0) ? 32'd0 : m_regs[rt_addr];
`ifdef ALU_OPERAND_WB_BYPASS_EN
    if (writes && wb_addr == rs_addr) ra  = wb_data;
    if (writes && wb_addr == rt_addr) rtv = wb_data;
`endif
    immv = 32'(imm);
    if (imm_sext && imm >= 16'h8000) immv = immv - 32'h0001_0000;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_valid = 0; m_rw = 0; m_a = 0; m_b = 0; m_rt = 0; m_ctrl = 0; m_rd = 0;
    end else begin
      if (flush) begin
        m_valid = 0; m_rw = 0;
      end else if (in_valid && model_ready()) begin
        m_valid = 1; m_a = ra; m_b = use_imm ? immv : rtv; m_rt = rtv;
        m_ctrl = alu_control_in; m_rd = rd_addr_in; m_rw = reg_write_in;
      end else if (m_valid && out_ready) begin
        m_valid = 0; m_rw = 0;
      end
      if (writes) m_regs[wb_addr] = wb_data;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; rs_addr = 0; rt_addr = 0; imm = 0; use_imm = 0; imm_sext = 0;
    alu_control_in = 0; rd_addr_in = 0; reg_write_in = 0; wb_en = 0; wb_addr = 0;
    wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic ui,
                       input logic sx, input logic [15:0] im, input logic [3:0] ctl);
    in_valid = 1; rs_addr = rs; rt_addr = rt; use_imm = ui; imm_sext = sx;
    imm = im; alu_control_in = ctl;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    vectors++;
    if ({out_valid, a, b, alu_control, rt_data, rd_addr_out, reg_write_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b a=%h b=%h ctl=%h rt=%h rd=%h rw=%b, want all 0",
               out_valid, a, b, alu_control, rt_data, rd_addr_out, reg_write_out);
    end
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    rst_n = 1;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    // Every register must read back as zero after reset.
    for (int i = 1; i < 32; i++) begin
      issue(5'(i), 5'(i), 0, 0, 16'h0, 4'h0);
      tick();
      vectors++;
      if (out_valid !== 1'b1 || a !== 32'd0 || rt_data !== 32'd0) begin
        errors++; $display("FAIL reset_read r%0d: got v=%b a=%h rt=%h want v=1 a=0 rt=0", i, out_valid, a, rt_data);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_write_read();
    idle_inputs();
    wb_en = 1; wb_addr = 5; wb_data = 32'h0000_00AA;
    tick();
    idle_inputs();
    issue(5, 0, 0, 0, 16'h0, 4'h0);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || a !== 32'hAA || b !== 32'd0 || alu_control !== 4'h0) begin
      errors++; $display("FAIL write_read: got v=%b a=%h b=%h ctl=%h want v=1 a=aa b=0 ctl=0", out_valid, a, b, alu_control);
    end
    idle_inputs();
    wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    issue(0, 0, 0, 0, 16'h0, 4'h1);
    tick();
    vectors++;
    if (a !== 32'd0 || rt_data !== 32'd0) begin
      errors++; $display("FAIL reg0_write_ignored: got a=%h rt=%h want 0", a, rt_data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_imm_ext();
    idle_inputs();
    issue(0, 0, 1, 1, 16'h8001, 4'h2);
    tick();
    vectors++;
    if (b !== 32'hFFFF_8001) begin errors++; $display("FAIL imm_sext: got %h want ffff8001", b); end
    issue(0, 0, 1, 0, 16'h8001, 4'h2);
    tick();
    vectors++;
    if (b !== 32'h0000_8001) begin errors++; $display("FAIL imm_zext: got %h want 00008001", b); end
    issue(0, 0, 1, 1, 16'h7FFF, 4'h2);
    tick();
    vectors++;
    if (b !== 32'h0000_7FFF) begin errors++; $display("FAIL imm_sext_pos: got %h want 00007fff", b); end
    idle_inputs();
    tick();
  endtask

  task automatic test_stall();
    idle_inputs();
    issue(0, 0, 1, 0, 16'h1111, 4'h3);
    tick();
    issue(5, 0, 1, 0, 16'h2222, 4'h7);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d: got %b want 0", i, in_ready); end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || a !== 32'd0 || b !== 32'h1111 || alu_control !== 4'h3) begin
        errors++; $display("FAIL stall_hold c%0d: got v=%b a=%h b=%h ctl=%h want v=1 a=0 b=1111 ctl=3", i, out_valid, a, b, alu_control);
      end
    end
    out_ready = 1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    tick();
    vectors++;
    if (a !== 32'hAA || b !== 32'h2222 || alu_control !== 4'h7) begin
      errors++; $display("FAIL stall_release: got a=%h b=%h ctl=%h want a=aa b=2222 ctl=7", a, b, alu_control);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    issue(5, 5, 0, 0, 16'h0, 4'h4);
    reg_write_in = 1; rd_addr_in = 9;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || reg_write_out !== 1'b1 || rd_addr_out !== 5'd9) begin
      errors++; $display("FAIL flush_setup: got v=%b rw=%b rd=%0d want 1 1 9", out_valid, reg_write_out, rd_addr_out);
    end
    flush = 1; wb_en = 1; wb_addr = 7; wb_data = 32'h1234;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || reg_write_out !== 1'b0) begin
      errors++; $display("FAIL flush_kill: got v=%b rw=%b want 0 0", out_valid, reg_write_out);
    end
    idle_inputs();
    issue(7, 0, 0, 0, 16'h0, 4'h0);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || a !== 32'h1234) begin
      errors++; $display("FAIL flush_wb_kept: got v=%b a=%h want v=1 a=1234", out_valid, a);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_same_edge();
    idle_inputs();
    wb_en = 1; wb_addr = 3; wb_data = 32'h10;
    tick();
    wb_data = 32'h20;
    issue(3, 3, 0, 0, 16'h0, 4'h5);
    tick();
    vectors++;
    if (a !== SAME_EDGE_EXP || b !== SAME_EDGE_EXP || rt_data !== SAME_EDGE_EXP) begin
      errors++; $display("FAIL same_edge: got a=%h b=%h rt=%h want %h", a, b, rt_data, SAME_EDGE_EXP);
    end
    idle_inputs();
    issue(3, 0, 0, 0, 16'h0, 4'h5);
    tick();
    vectors++;
    if (a !== 32'h20) begin errors++; $display("FAIL same_edge_after: got a=%h want 20", a); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    idle_inputs();
    issue(5, 7, 0, 0, 16'h0, 4'h6);
    reg_write_in = 1;
    tick();
    out_ready = 0; in_valid = 1;
    tick();
    rst_n = 0;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL midstall_rst_ready: got %b want 0", in_ready); end
    tick();
    vectors++;
    if ({out_valid, a, b, alu_control, rt_data, rd_addr_out, reg_write_out} !== '0) begin
      errors++; $display("FAIL midstall_rst: got v=%b a=%h b=%h rw=%b want all 0", out_valid, a, b, reg_write_out);
    end
    rst_n = 1;
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n          = ($urandom_range(0, 59) != 0);
      in_valid       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 15) == 0);
      rs_addr        = 5'($urandom_range(0, 7));
      rt_addr        = 5'($urandom_range(0, 7));
      imm            = 16'($urandom);
      use_imm        = 1'($urandom);
      imm_sext       = 1'($urandom);
      alu_control_in = 4'($urandom);
      rd_addr_in     = 5'($urandom);
      reg_write_in   = 1'($urandom);
      wb_en          = 1'($urandom);
      wb_addr        = 5'($urandom_range(0, 7));
      wb_data        = $urandom;
      #1;
      vectors++;
      if (in_ready !== model_ready()) begin
        errors++; $display("FAIL rand_in_ready #%0d: got %b want %b", i, in_ready, model_ready());
      end
      tick();
      vectors++;
      if ({out_valid, a, b, alu_control, rt_data, rd_addr_out, reg_write_out} !==
          {m_valid, m_a, m_b, m_ctrl, m_rt, m_rd, m_rw}) begin
        errors++;
        $display("FAIL rand_out #%0d: got v=%b a=%h b=%h ctl=%h rt=%h rd=%0d rw=%b want v=%b a=%h b=%h ctl=%h rt=%h rd=%0d rw=%b",
                 i, out_valid, a, b, alu_control, rt_data, rd_addr_out, reg_write_out,
                 m_valid, m_a, m_b, m_ctrl, m_rt, m_rd, m_rw);
      end
    end
    rst_n = 1;
    idle_inputs();
    tick();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_imm_ext();
    test_stall();
    test_flush();
    test_same_edge();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Decode/operand stage directly upstream of the 32-bit ALU.
- Holds the 32x32 general register file: two read ports and one write-back port.
- Forms ALU operands `a`/`b`: `b` is either the rt value or an extended 16-bit immediate.
- Registers `a`, `b` and `alu_control` in a single-entry pipeline register with valid/ready handshake, stall and flush.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_ADDR_W, 5, register address width (2**REG_ADDR_W registers).
- CTRL_W, 4, alu_control width.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage can accept this cycle
- rs_addr  input  REG_ADDR_W  source register for `a`
- rt_addr  input  REG_ADDR_W  source register for `b` / store data
- imm  input  16  instruction immediate
- use_imm  input  1  1: `b` = extended imm; 0: `b` = reg[rt]
- imm_sext  input  1  1: sign-extend imm; 0: zero-extend (andi/ori)
- alu_control_in  input  CTRL_W  ALU op, passed through
- rd_addr_in  input  REG_ADDR_W  destination register, passed through
- reg_write_in  input  1  instruction writes back, passed through
- wb_en  input  1  write-back enable
- wb_addr  input  REG_ADDR_W  write-back register
- wb_data  input  DATA_W  write-back data
- flush  input  1  kill the held and incoming instruction
- out_valid  output  1  registered operands valid
- out_ready  input  1  ALU stage consumes this cycle
- a  output  DATA_W  ALU operand a
- b  output  DATA_W  ALU operand b
- alu_control  output  CTRL_W  ALU op
- rt_data  output  DATA_W  reg[rt], store/bne data
- rd_addr_out  output  REG_ADDR_W  destination register
- reg_write_out  output  1  write-back flag; 0 whenever out_valid=0

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All registers in the file cleared to 0.
  - out_valid=0; a, b, rt_data, alu_control, rd_addr_out and reg_write_out all 0.
  - in_ready=0 while rst_n=0.
- Register file:
  - reg[0] always reads 0; writes to address 0 are ignored.
  - Write occurs at the clk edge when wb_en=1 and wb_addr!=0.
  - Reads are combinational from the array and are sampled into the pipeline register at the capture edge.
- Handshake:
  - in_ready = rst_n & (!out_valid | out_ready).
  - Capture when in_valid & in_ready: out_valid<=1, and all outputs are loaded from the current inputs and reads.
  - Latency is 1 cycle, input to out_valid.
  - If out_valid & out_ready & !in_valid, then out_valid<=0.
  - If out_valid & !out_ready (stall), all outputs hold stable and in_ready=0.
  - Full throughput is 1 instruction per cycle when out_ready=1 continuously.
- Immediate:
  - imm_sext=1: b = {{16{imm[15]}}, imm}.
  - imm_sext=0: b = {16'b0, imm}.
  - DATA_W>32 extends using the same rule; the shift amount for sll is b unchanged.
- Flush:
  - Highest priority after reset: out_valid<=0, reg_write_out<=0, and no capture that cycle.
  - in_ready is unaffected. A write-back in the same cycle still occurs.
- Held entry is not refreshed: operands captured before a later write-back keep their old values. Hazard resolution belongs to the upstream control.
- Same-edge read/write of the same register (wb_en=1, wb_addr==rs_addr or rt_addr, capture this cycle): the captured value is the OLD register content, unless the optional feature below is enabled.
- Reset asserted mid-stall discards the held instruction; there is no output glitch beyond the cleared values.

Optional Feature:
- Macro: ALU_OPERAND_WB_BYPASS_EN
- Defined: on a same-edge read/write hit (wb_en=1, wb_addr!=0, address match), `a`, `b` (when use_imm=0) and rt_data capture wb_data instead of the array content. reg[0] is never bypassed.
- Undefined: old array content is captured, as stated above.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 → out_valid=0, all outputs 0; reads of reg 1..31 return 0.
- Write/read: write reg5=0x0000_00AA; next cycle issue rs=5, rt=0, use_imm=0, alu_control=0000 → one cycle later out_valid=1, a=0xAA, b=0. Write to reg0=0xFFFF_FFFF → reg0 still reads 0.
- Immediate extension: imm=0x8001 with imm_sext=1 → b=0xFFFF_8001; with imm_sext=0 → b=0x0000_8001.
- Stall: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and a/b/alu_control stable; out_ready=1 → the next instruction is captured 1 cycle later.
- Flush: flush=1 while out_valid=1 and in_valid=1 → next cycle out_valid=0 and reg_write_out=0; a concurrent wb to reg7=0x1234 is still visible on a later read.
- Same-edge hit: reg3=0x10, then in the same cycle wb reg3=0x20 and capture rs=3 → a=0x10 without ALU_OPERAND_WB_BYPASS_EN, a=0x20 with it.
